non_max_suppr_pipe: RTL and testbench
=====================================

Name: non_max_suppr_pipe

Overview:
Parametrised, pipelined successor to the Canny non-maximum suppression stage. It takes a packed 3x3 gradient-magnitude window plus the quantised gradient direction of the centre pixel, and suppresses the centre unless it is a local maximum along that direction. It adds valid/ready flow control, a selectable tie-break mode, frame-position tracking with border zeroing, and end-of-line/frame markers. It sits between the magnitude/direction window generators and the double-threshold stage.

Parameters:
DATA_W, 8, magnitude pixel width in bits
DIR_W, 8, direction code width
IMG_W, 512, image width in pixels (>=3)
IMG_H, 512, image height in pixels (>=3)
BORDER_ZERO, 1, 1 = force outermost rows/columns to 0; 0 = pass NMS result

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_mag  in  9*DATA_W  3x3 magnitude window
in_dir  in  DIR_W  quantised direction of centre pixel
in_sof  in  1  first pixel of frame
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
cmp_mode  in  1  tie-break mode, sampled per accepted beat
out_data  out  DATA_W  suppressed magnitude
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_eol  out  1  beat is last pixel of a row
out_eof  out  1  beat is last pixel of frame
out_dir_err  out  1  beat had an illegal direction code

Behaviour:
- Window packing: pixel at row r (0=top), column c (0=left) occupies in_mag[(3*r+2-c)*DATA_W +: DATA_W]. Centre C = index 4.
- Direction codes, neighbours (A, B):
  - 1 horizontal: A=index 3 (right), B=index 5 (left)
  - 2 diagonal TL-BR: A=index 6 (bottom-right), B=index 2 (top-left)
  - 3 vertical: A=index 7 (bottom), B=index 1 (top)
  - 4 diagonal BL-TR: A=index 8 (bottom-left), B=index 0 (top-right)
  - Any other code: result 0, out_dir_err=1 for that beat.
- Suppression, unsigned compares:
  - cmp_mode=0: result 0 if C<A or C<B, else C. Ties are kept.
  - cmp_mode=1: result 0 if C<=A or C<B, else C. Asymmetric tie-break, so exactly one plateau pixel survives.
- Position tracking:
  - col/row counters advance on each accepted input beat (in_valid&&in_ready).
  - Accepted beat with in_sof=1 is taken as (0,0), overriding the counters.
  - col wraps at IMG_W-1 to 0 and increments row; row wraps at IMG_H-1 to 0.
- Border: if BORDER_ZERO=1 and col==0, col==IMG_W-1, row==0 or row==IMG_H-1, result=0 regardless of direction. out_dir_err still reports an illegal code.
- out_eol=1 when col==IMG_W-1; out_eof=1 when col==IMG_W-1 and row==IMG_H-1.
- Pipeline: 2 register stages.
  - S1 registers compare flags, C, position flags and mode.
  - S2 registers the final outputs.
  - Common enable en = !out_valid || out_ready; in_ready = en. Both stages shift on en, and valid bits shift with the data.
- Latency: 2 cycles from accepted beat to out_valid when out_ready is held high. Full throughput of 1 beat/cycle.
- Stall: while out_valid && !out_ready, all outputs and stage contents hold stable and in_ready=0. No beat is lost or duplicated.
- Reset: asynchronous, active-high.
  - All valid bits, out_data, out_eol, out_eof, out_dir_err and the counters go to 0.
  - in_ready=1 after reset (out_valid=0).
  - Beats in flight are discarded. After reset the first accepted beat is (0,0) whether or not in_sof is set.
- in_sof on a beat not at counter position (0,0) re-synchronises silently; the partial frame is not flagged.

Test Plan:
- cmp_mode=0, BORDER_ZERO=0, dir=1, C=100, left=100, right=90 -> out_data=100 two cycles after accept; with right=101 -> out_data=0.
- cmp_mode=1, dir=3, C=50, bottom=50, top=10 -> 0; C=50, top=50, bottom=10 -> 50. Repeat for dir 2 and 4 with the corresponding diagonal indices.
- dir=0 and dir=7, C=200, all neighbours 0 -> out_data=0, out_dir_err=1; dir=1 on the next beat -> out_dir_err=0.
- IMG_W=4, IMG_H=3, BORDER_ZERO=1, stream 12 beats of all-100 windows with dir=1 and sof on the first -> only beats at (1,1) and (2,1) are 100; out_eol on beats 4, 8, 12; out_eof on beat 12 only.
- Random out_ready toggling with continuous in_valid over 1000 beats -> output sequence matches the reference model exactly; out_data stable while out_valid && !out_ready.
- Assert rst mid-stream with 2 beats in flight -> out_valid=0 immediately (asynchronously); the next accepted beat reports position (0,0), and out_eol occurs on the IMG_W-th beat after reset.

Source files
------------

// File: rtl/non_max_suppr_pipe_if.sv
// Stream interface for the non-maximum suppression pipe: window/direction in, suppressed pixel out.
// The slave modport is the pipe's own view; master is the surrounding environment.
interface non_max_suppr_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIR_W  = 8
);
  logic [9*DATA_W-1:0] in_mag;
  logic [DIR_W-1:0]    in_dir;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;
  logic                cmp_mode;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_eol;
  logic                out_eof;
  logic                out_dir_err;

  modport master (
    output in_mag, in_dir, in_sof, in_valid, cmp_mode, out_ready,
    input  in_ready, out_data, out_valid, out_eol, out_eof, out_dir_err
  );

  modport slave (
    input  in_mag, in_dir, in_sof, in_valid, cmp_mode, out_ready,
    output in_ready, out_data, out_valid, out_eol, out_eof, out_dir_err
  );
endinterface

// File: rtl/non_max_suppr_pipe.sv
// Two-stage pipelined Canny non-maximum suppression with valid/ready flow control,
// frame-position tracking, optional border zeroing and end-of-line/frame markers.
module non_max_suppr_pipe #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIR_W       = 8,
  parameter int unsigned IMG_W       = 512,
  parameter int unsigned IMG_H       = 512,
  parameter int unsigned BORDER_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  non_max_suppr_pipe_if.slave    bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned NPIX  = 9;

  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic              c_lt_a;
    logic              c_le_a;
    logic              c_lt_b;
    logic              dir_err;
    logic              border;
    logic              eol;
    logic              eof;
    logic              mode;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eol;
    logic              eof;
    logic              dir_err;
  } s2_t;

  logic [COL_W-1:0]  col_q, col_d, cur_col;
  logic [ROW_W-1:0]  row_q, row_d, cur_row;
  logic              last_col, last_row;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s2_vld_q, s2_vld_d;
  logic              en_c, accept_c;
  logic [DATA_W-1:0] pix [NPIX];
  logic [DATA_W-1:0] nb_a, nb_b;
  logic              dir_err;
  logic              suppress;
  logic              zero_out;

  // Both stages advance together whenever the output register is free or draining.
  assign en_c         = !s2_vld_q || bus.out_ready;
  assign accept_c     = bus.in_valid && en_c;
  assign bus.in_ready = en_c;

  // Unpack the window: row r, column c lives at index 3*r + 2 - c.
  always_comb begin
    for (int unsigned i = 0; i < NPIX; i++) begin
      pix[i] = bus.in_mag[i*DATA_W +: DATA_W];
    end
  end

  // Neighbour pair along the quantised gradient direction.
  always_comb begin
    nb_a    = '0;
    nb_b    = '0;
    dir_err = 1'b1;
    case (bus.in_dir)
      DIR_W'(1): begin nb_a = pix[3]; nb_b = pix[5]; dir_err = 1'b0; end
      DIR_W'(2): begin nb_a = pix[6]; nb_b = pix[2]; dir_err = 1'b0; end
      DIR_W'(3): begin nb_a = pix[7]; nb_b = pix[1]; dir_err = 1'b0; end
      DIR_W'(4): begin nb_a = pix[8]; nb_b = pix[0]; dir_err = 1'b0; end
      default:   begin nb_a = '0;     nb_b = '0;     dir_err = 1'b1; end
    endcase
  end

  // Position of the beat being offered; a start-of-frame beat is always (0,0).
  always_comb begin
    cur_col  = bus.in_sof ? '0 : col_q;
    cur_row  = bus.in_sof ? '0 : row_q;
    last_col = (cur_col == COL_W'(IMG_W - 1));
    last_row = (cur_row == ROW_W'(IMG_H - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (accept_c) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // Stage 1: compare flags, centre value and position flags.
  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = s1_vld_q;
    if (en_c) begin
      s1_vld_d = bus.in_valid;
    end
    if (accept_c) begin
      s1_d.c       = pix[4];
      s1_d.c_lt_a  = (pix[4] <  nb_a);
      s1_d.c_le_a  = (pix[4] <= nb_a);
      s1_d.c_lt_b  = (pix[4] <  nb_b);
      s1_d.dir_err = dir_err;
      s1_d.border  = (BORDER_ZERO != 0) &&
                     ((cur_col == '0) || last_col || (cur_row == '0) || last_row);
      s1_d.eol     = last_col;
      s1_d.eof     = last_col && last_row;
      s1_d.mode    = bus.cmp_mode;
    end
  end

  // Stage 2: resolve suppression and register the outgoing beat.
  always_comb begin
    suppress = s1_q.mode ? (s1_q.c_le_a || s1_q.c_lt_b)
                         : (s1_q.c_lt_a || s1_q.c_lt_b);
    zero_out = suppress || s1_q.dir_err || s1_q.border;
    s2_d     = s2_q;
    s2_vld_d = s2_vld_q;
    if (en_c) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d.data    = zero_out ? '0 : s1_q.c;
        s2_d.eol     = s1_q.eol;
        s2_d.eof     = s1_q.eof;
        s2_d.dir_err = s1_q.dir_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_q     <= s2_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  assign bus.out_data    = s2_q.data;
  assign bus.out_valid   = s2_vld_q;
  assign bus.out_eol     = s2_q.eol;
  assign bus.out_eof     = s2_q.eof;
  assign bus.out_dir_err = s2_q.dir_err;

endmodule

// File: tb/tb_non_max_suppr_pipe.sv
// Bench for non_max_suppr_pipe: two instances (border zeroing off/on) on a 4x3 image,
// driven by a common stimulus stream and checked against hand-computed vectors and a model.
module tb_non_max_suppr_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 8;
  localparam int IW = 4;
  localparam int IH = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
    logic       err;
  } rec_t;

  typedef struct {
    logic [71:0] m;
    logic [7:0]  d;
    logic        md;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] mag;
  logic [7:0]  dir;
  logic        sof, vld, mode, ordy;

  always #5 clk = ~clk;

  non_max_suppr_pipe_if #(.DATA_W(DW), .DIR_W(RW)) if0 ();
  non_max_suppr_pipe_if #(.DATA_W(DW), .DIR_W(RW)) if1 ();

  assign if0.in_mag = mag;  assign if1.in_mag = mag;
  assign if0.in_dir = dir;  assign if1.in_dir = dir;
  assign if0.in_sof = sof;  assign if1.in_sof = sof;
  assign if0.in_valid = vld;  assign if1.in_valid = vld;
  assign if0.cmp_mode = mode; assign if1.cmp_mode = mode;
  assign if0.out_ready = ordy; assign if1.out_ready = ordy;

  non_max_suppr_pipe #(.DATA_W(DW), .DIR_W(RW), .IMG_W(IW), .IMG_H(IH), .BORDER_ZERO(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  non_max_suppr_pipe #(.DATA_W(DW), .DIR_W(RW), .IMG_W(IW), .IMG_H(IH), .BORDER_ZERO(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t got0[$], got1[$], exp0[$], exp1[$];
  bit   mon_en = 1'b0;
  bit   held_v = 1'b0;
  rec_t held0;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input rec_t g, input rec_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got data=%0d eol=%0b eof=%0b err=%0b expected data=%0d eol=%0b eof=%0b err=%0b",
               nm, g.data, g.eol, g.eof, g.err, e.data, e.eol, e.eof, e.err);
    end
  endtask

  function automatic rec_t mk(input logic [7:0] d, input logic eol, input logic eof, input logic err);
    rec_t r;
    r.data = d; r.eol = eol; r.eof = eof; r.err = err;
    return r;
  endfunction

  function automatic logic [71:0] win(input logic [7:0] c, input int ia, input logic [7:0] va,
                                      input int ib, input logic [7:0] vb);
    logic [71:0] w;
    w = '0;
    w[32 +: 8]   = c;
    w[ia*8 +: 8] = va;
    w[ib*8 +: 8] = vb;
    return w;
  endfunction

  // Reference behaviour of one beat at a known frame position.
  function automatic rec_t model(input logic [71:0] m, input logic [7:0] d, input logic md,
                                 input int col, input int row, input bit bz);
    logic [7:0] c, a, b;
    bit err, sup, brd;
    rec_t r;
    c = m[32 +: 8]; a = 8'd0; b = 8'd0; err = 1'b0;
    case (d)
      8'd1: begin a = m[24 +: 8]; b = m[40 +: 8]; end
      8'd2: begin a = m[48 +: 8]; b = m[16 +: 8]; end
      8'd3: begin a = m[56 +: 8]; b = m[8 +: 8];  end
      8'd4: begin a = m[64 +: 8]; b = m[0 +: 8];  end
      default: err = 1'b1;
    endcase
    sup    = md ? ((c <= a) || (c < b)) : ((c < a) || (c < b));
    brd    = bz && (col == 0 || col == IW-1 || row == 0 || row == IH-1);
    r.data = (err || brd || sup) ? 8'd0 : c;
    r.eol  = (col == IW-1);
    r.eof  = (col == IW-1) && (row == IH-1);
    r.err  = err;
    return r;
  endfunction

  function automatic rec_t rd0();
    return mk(if0.out_data, if0.out_eol, if0.out_eof, if0.out_dir_err);
  endfunction

  function automatic rec_t rd1();
    return mk(if1.out_data, if1.out_eol, if1.out_eof, if1.out_dir_err);
  endfunction

  // Output collection and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (if0.out_valid && ordy) got0.push_back(rd0());
      if (if1.out_valid && ordy) got1.push_back(rd1());
      if (held_v && if0.out_valid) chk_rec("stall_hold", rd0(), held0);
      held_v = if0.out_valid && !ordy;
      held0  = rd0();
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_vld0"}, 32'(if0.out_valid), 0);
    chk({nm, "_vld1"}, 32'(if1.out_valid), 0);
    chk({nm, "_rdy"},  32'(if0.in_ready), 1);
    chk({nm, "_data"}, 32'(if0.out_data), 0);
    chk({nm, "_flags"}, 32'({if0.out_eol, if0.out_eof, if0.out_dir_err}), 0);
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 200 && got1.size() < n; k++) tick();
    chk("out_count0", 32'(got0.size()), 32'(n));
    chk("out_count1", 32'(got1.size()), 32'(n));
  endtask

  logic [71:0] bm;
  logic [7:0]  bd;
  logic        bmd, bs, acc;
  int          mcol, mrow, sent, lat;
  rec_t        e0, e1;

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 4) * 60);
    return w;
  endfunction

  task automatic new_beat();
    bm  = rand_win();
    bd  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255));
    bmd = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{win(8'd100, 3, 8'd90,  5, 8'd100), 8'd1, 1'b0, 8'd100, 1'b0};
    tbl[1]  = '{win(8'd100, 3, 8'd101, 5, 8'd100), 8'd1, 1'b0, 8'd0,   1'b0};
    tbl[2]  = '{win(8'd50,  7, 8'd50,  1, 8'd10),  8'd3, 1'b1, 8'd0,   1'b0};
    tbl[3]  = '{win(8'd50,  7, 8'd10,  1, 8'd50),  8'd3, 1'b1, 8'd50,  1'b0};
    tbl[4]  = '{win(8'd50,  6, 8'd50,  2, 8'd10),  8'd2, 1'b1, 8'd0,   1'b0};
    tbl[5]  = '{win(8'd50,  6, 8'd10,  2, 8'd50),  8'd2, 1'b1, 8'd50,  1'b0};
    tbl[6]  = '{win(8'd50,  8, 8'd50,  0, 8'd10),  8'd4, 1'b1, 8'd0,   1'b0};
    tbl[7]  = '{win(8'd50,  8, 8'd10,  0, 8'd50),  8'd4, 1'b1, 8'd50,  1'b0};
    tbl[8]  = '{win(8'd50,  7, 8'd50,  1, 8'd10),  8'd3, 1'b0, 8'd50,  1'b0};
    tbl[9]  = '{win(8'd200, 3, 8'd0,   5, 8'd0),   8'd0, 1'b0, 8'd0,   1'b1};
    tbl[10] = '{win(8'd200, 3, 8'd0,   5, 8'd0),   8'd7, 1'b0, 8'd0,   1'b1};
    tbl[11] = '{win(8'd200, 3, 8'd0,   5, 8'd0),   8'd1, 1'b0, 8'd200, 1'b0};
    tbl[12] = '{win(8'd5,   3, 8'd3,   5, 8'd6),   8'd1, 1'b0, 8'd0,   1'b0};
    tbl[13] = '{win(8'd7,   3, 8'd7,   5, 8'd7),   8'd1, 1'b1, 8'd0,   1'b0};
    tbl[14] = '{win(8'd7,   3, 8'd7,   5, 8'd7),   8'd1, 1'b0, 8'd7,   1'b0};
    tbl[15] = '{win(8'd200, 3, 8'd100, 5, 8'd0),   8'd1, 1'b1, 8'd200, 1'b0};
    tbl[16] = '{win(8'd100, 3, 8'd200, 5, 8'd0),   8'd1, 1'b0, 8'd0,   1'b0};
    tbl[17] = '{win(8'd90,  8, 8'd1,   0, 8'd2),   8'd255, 1'b0, 8'd0, 1'b1};

    rst = 1'b1; vld = 1'b0; sof = 1'b0; mode = 1'b0; ordy = 1'b1;
    mag = '0; dir = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Single beats with hand-computed results and latency.
    for (int i = 0; i < 18; i++) begin
      mag = tbl[i].m; dir = tbl[i].d; mode = tbl[i].md; sof = 1'b0; vld = 1'b1;
      chk($sformatf("tbl%0d_ready", i), 32'(if0.in_ready), 1);
      tick();
      vld = 1'b0;
      lat = 1;
      while (lat < 8 && !if0.out_valid) begin tick(); lat++; end
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 2);
      chk($sformatf("tbl%0d_data", i), 32'(if0.out_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_dir_err", i), 32'(if0.out_dir_err), 32'(tbl[i].exp_err));
    end
    tick();

    // Full 4x3 frame of flat windows; sof re-aligns the counters mid-frame.
    got0.delete(); got1.delete(); mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mag = {9{8'd100}}; dir = 8'd1; mode = 1'b0; sof = (i == 0); vld = 1'b1;
      tick();
    end
    vld = 1'b0; sof = 1'b0;
    wait_outputs(12);
    for (int i = 0; i < 12 && i < got1.size() && i < got0.size(); i++) begin
      chk_rec($sformatf("frame%0d_bz0", i), got0[i], mk(8'd100, (i % 4) == 3, i == 11, 1'b0));
      chk_rec($sformatf("frame%0d_bz1", i), got1[i],
              mk((i == 5 || i == 6) ? 8'd100 : 8'd0, (i % 4) == 3, i == 11, 1'b0));
    end

    // Continuous input with random backpressure against the model.
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    mcol = 0; mrow = 0; sent = 0; bs = 1'b1;
    new_beat();
    for (int cyc = 0; cyc < 6000 && sent < 1000; cyc++) begin
      mag = bm; dir = bd; mode = bmd; sof = bs; vld = 1'b1;
      ordy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = if0.in_ready;
      tick();
      if (acc) begin
        if (bs) begin mcol = 0; mrow = 0; end
        exp0.push_back(model(bm, bd, bmd, mcol, mrow, 1'b0));
        exp1.push_back(model(bm, bd, bmd, mcol, mrow, 1'b1));
        if (mcol == IW-1) begin
          mcol = 0;
          mrow = (mrow == IH-1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
        sent++;
        bs = 1'b0;
        new_beat();
      end
    end
    vld = 1'b0; sof = 1'b0; ordy = 1'b1;
    chk("rand_sent", 32'(sent), 1000);
    wait_outputs(exp0.size());
    for (int i = 0; i < exp0.size() && i < got0.size() && i < got1.size(); i++) begin
      chk_rec($sformatf("rand%0d_bz0", i), got0[i], exp0[i]);
      chk_rec($sformatf("rand%0d_bz1", i), got1[i], exp1[i]);
    end

    // Reset with two beats in flight, then confirm the position restarts at (0,0).
    mon_en = 1'b0;
    mag = {9{8'd100}}; dir = 8'd1; mode = 1'b0; sof = 1'b1; vld = 1'b1; ordy = 1'b1;
    tick();
    sof = 1'b0;
    tick();
    chk("inflight_valid", 32'(if0.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    got0.delete(); got1.delete(); mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mag = {9{8'd100}}; dir = 8'd1; mode = 1'b0; sof = 1'b0; vld = 1'b1;
      tick();
    end
    vld = 1'b0;
    wait_outputs(6);
    for (int i = 0; i < 6 && i < got0.size() && i < got1.size(); i++) begin
      chk_rec($sformatf("post_rst%0d_bz0", i), got0[i], mk(8'd100, i == 3, 1'b0, 1'b0));
      chk_rec($sformatf("post_rst%0d_bz1", i), got1[i],
              mk((i == 5) ? 8'd100 : 8'd0, i == 3, 1'b0, 1'b0));
    end
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
